fifo_uart_tx: RTL and testbench

Serial transmit stage for RFID/RSA result bytes. Drains bytes from the 8-bit byte FIFO loaded by the word-to-byte packer, one at a time, and shifts each out LSB-first as an 8N1 UART frame (optionally 8E1) on `tx`. The FIFO is a normal-mode single-clock FIFO with registered read data. `fifo_q` is valid on the cycle after the cycle in which `fifo_rdreq` is high.

---
 rtl/uart_pkg.sv | 17 +
 rtl/fifo_uart_tx_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and constants for the FIFO-fed UART transmitter
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_CLK_DIV_115200 = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - byte FIFO read port and UART line signals of the transmit stage
interface fifo_uart_tx_if;

  logic [uart_pkg::UART_DATA_BITS-1:0] fifo_q;
  logic                                fifo_empty;
  logic                                fifo_rdreq;
  logic                                tx;
  logic                                busy;
  logic                                byte_done;

  // master is the transmitter, slave is the FIFO/line side
  modport master (
    input  fifo_q, fifo_empty,
    output fifo_rdreq, tx, busy, byte_done
  );

  modport slave (
    output fifo_q, fifo_empty,
    input  fifo_rdreq, tx, busy, byte_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider; tick marks the last cycle of each UART bit
module uart_baud_gen #(
  parameter int CLK_DIV = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the byte FIFO into 8N1 UART frames; UART_PARITY_EN adds an even parity bit (8E1)
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_115200
) (
  input  logic             clock,
  input  logic             reset,
  fifo_uart_tx_if.master   bus
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]                  idx_q, idx_d;
  logic                        tx_q, tx_d;
  logic                        rdreq_q, rdreq_d;
  logic                        done_q, done_d;
  logic                        tick;
  logic                        clear;
`ifdef UART_PARITY_EN
  logic                        par_q, par_d;
`endif

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      rdreq_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rdreq_q <= rdreq_d;
      done_q  <= done_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // fifo_empty is only looked at in IDLE, so a frame in flight ignores the FIFO
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!bus.fifo_empty) state_d = READ;
      READ:  state_d = LOAD;
      LOAD:  state_d = START;
      START: if (tick) state_d = DATA;
`ifdef UART_PARITY_EN
      DATA:   if (tick && (idx_q == LAST_BIT)) state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
`else
      DATA:   if (tick && (idx_q == LAST_BIT)) state_d = STOP;
`endif
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    rdreq_d = 1'b0;
    done_d  = 1'b0;
    clear   = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        rdreq_d = !bus.fifo_empty;
      end
      LOAD: begin
        // fifo_q is valid here, one cycle after the pop edge
        shift_d = bus.fifo_q;
        tx_d    = 1'b0;
        clear   = 1'b1;
`ifdef UART_PARITY_EN
        par_d   = ^bus.fifo_q;
`endif
      end
      START: if (tick) begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        idx_d   = '0;
      end
      DATA: if (tick) begin
        if (idx_q != LAST_BIT) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
        end else begin
`ifdef UART_PARITY_EN
          tx_d = par_q;
`else
          tx_d = 1'b1;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) tx_d = 1'b1;
`endif
      STOP: if (tick) done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.fifo_rdreq = rdreq_q;
  assign bus.tx         = tx_q;
  assign bus.byte_done  = done_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench: FIFO model, frame decoder scoreboard, vector table
module tb_fifo_uart_tx;

  localparam int DIV = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = DIV * NBITS;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // {stop, parity, data[7:0], start}, bit 0 sent first
  } vec_t;

  logic clock;
  logic reset;
  fifo_uart_tx_if bus();

  fifo_uart_tx #(.CLK_DIV(DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  fifo_mem[$];
  logic [10:0] sb[$];
  int          falls[$];
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  bit          mon_active = 0;
  int          mon_cnt = 0;
  int          mon_idx = 0;
  logic [10:0] obs = '0;
  logic        prev_tx = 1'b1;
  vec_t        vecs[6];
  int          rd0, dn0;
  bit          found;
  bit          bad_rd, bad_tx, bad_busy;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] squash(input logic [10:0] f);
`ifdef UART_PARITY_EN
    return f;
`else
    return {1'b0, f[10], f[8:0]};
`endif
  endfunction

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && fifo_mem.size() == 0 && !bus.busy && !mon_active) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle_bound", int'(ok), 1);
    repeat (3) @(negedge clock);
  endtask

  // FIFO model: registered read data, popped when rdreq is seen
  initial begin
    bus.fifo_q     = '0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.fifo_rdreq) begin
        rd_cnt++;
        chk("rdreq_while_empty", int'(fifo_mem.size() != 0), 1);
        if (fifo_mem.size() != 0) bus.fifo_q = fifo_mem.pop_front();
      end
      bus.fifo_empty = (fifo_mem.size() == 0);
    end
  end

  // line decoder: samples each bit mid-period, compares whole frames against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (bus.byte_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (!reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (prev_tx && !bus.tx) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          obs        = '0;
          falls.push_back(cyc);
        end
      end else begin
        mon_cnt++;
      end
      if (mon_active && (mon_cnt % DIV) == DIV / 2) begin
        mon_idx = mon_cnt / DIV;
        obs[mon_idx] = bus.tx;
        if (mon_idx == 0) chk("busy_in_frame", int'(bus.busy), 1);
        if (mon_idx == NBITS - 1) begin
          mon_active = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", obs);
          end else begin
            chk("frame", int'(obs), int'(squash(sb.pop_front())));
          end
        end
      end
      prev_tx = bus.tx;
    end
  end

  initial begin
    vecs[0] = '{8'h55, 11'b1_0_01010101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{8'h81, 11'b1_0_10000001_0};
    vecs[5] = '{8'h01, 11'b1_1_00000001_0};

    // reset held with a byte waiting
    reset = 1'b0;
    fifo_mem.push_back(8'h55);
    sb.push_back(11'b1_0_01010101_0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_tx", int'(bus.tx), 1);
      chk("reset_rdreq", int'(bus.fifo_rdreq), 0);
      chk("reset_busy", int'(bus.busy), 0);
    end
    chk("reset_done", int'(bus.byte_done), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rdreq_after_release", int'(bus.fifo_rdreq), 1);
    wait_idle(400);
    chk("first_rdreq_cycles", rd_cnt, 1);
    chk("first_done_pulses", done_cnt, 1);
    chk("first_frame_len", last_done_cyc - falls[falls.size()-1], FRAME_CYC);

    for (int i = 0; i < 6; i++) begin
      rd0 = rd_cnt;
      dn0 = done_cnt;
      fifo_mem.push_back(vecs[i].data);
      sb.push_back(vecs[i].frame);
      wait_idle(400);
      chk("vec_rdreq_cycles", rd_cnt - rd0, 1);
      chk("vec_done_pulses", done_cnt - dn0, 1);
      chk("vec_frame_len", last_done_cyc - falls[falls.size()-1], FRAME_CYC);
    end

    // back-to-back frames
    rd0 = rd_cnt;
    dn0 = done_cnt;
    fifo_mem.push_back(8'hA5);
    fifo_mem.push_back(8'h3C);
    sb.push_back(11'b1_0_10100101_0);
    sb.push_back(11'b1_0_00111100_0);
    wait_idle(600);
    chk("b2b_rdreq_cycles", rd_cnt - rd0, 2);
    chk("b2b_done_pulses", done_cnt - dn0, 2);
    chk("b2b_spacing", falls[falls.size()-1] - falls[falls.size()-2], FRAME_CYC + 3);

    // empty FIFO stays quiet
    bad_rd = 1'b0; bad_tx = 1'b0; bad_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      bad_rd   = bad_rd   | bus.fifo_rdreq;
      bad_tx   = bad_tx   | !bus.tx;
      bad_busy = bad_busy | bus.busy;
    end
    chk("empty_rdreq", int'(bad_rd), 0);
    chk("empty_tx_low", int'(bad_tx), 0);
    chk("empty_busy", int'(bad_busy), 0);

    // reset during the third data bit of 0xF0; 0x81 must follow
    rd0 = rd_cnt;
    dn0 = done_cnt;
    fifo_mem.push_back(8'hF0);
    fifo_mem.push_back(8'h81);
    sb.push_back(11'b1_0_10000001_0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!bus.tx) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_fall_seen", int'(found), 1);
    repeat (13) @(negedge clock);
    chk("mid_pre_reset_tx", int'(bus.tx), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_reset_tx", int'(bus.tx), 1);
    chk("mid_reset_busy", int'(bus.busy), 0);
    chk("mid_reset_done", int'(bus.byte_done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_idle(400);
    chk("mid_done_pulses", done_cnt - dn0, 1);
    chk("mid_rdreq_cycles", rd_cnt - rd0, 2);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
